vxm_stream_exec: RTL and testbench
==================================

Name: vxm_stream_exec

Overview:
- Single-instruction vector execute stage that sits between the instruction dispatcher and the streaming register file (SRF).
- Accepts one vector instruction (op, src1, src2, dest) over a valid/ready handshake. It then sequences an SRF read of two source streams and computes an element-wise 16-bit result across every tile of the slice. Finally it drives a one-cycle SRF write of the result to the destination stream.
- It is the SRF's only read/write master in the slice.

Parameters:
- NUM_STREAM_ID, 5, width of stream identifiers.
- MIN_VEC_LENGTH, 16, bits per tile element.
- NUM_TILES_PER_SLICE, 20, elements per stream vector.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  dispatcher presents an instruction.
- instr_ready  out  1  block can accept an instruction.
- instr_op  in  4  opcode (see Behaviour).
- instr_src1  in  NUM_STREAM_ID  first source stream.
- instr_src2  in  NUM_STREAM_ID  second source stream.
- instr_dest  in  NUM_STREAM_ID  destination stream.
- srf_read_enable  out  1  SRF read strobe.
- stream_src1  out  NUM_STREAM_ID  SRF read address 1.
- stream_src2  out  NUM_STREAM_ID  SRF read address 2.
- srf_data1  in  MIN_VEC_LENGTH x NUM_TILES_PER_SLICE  SRF read data 1 (registered in SRF, valid the cycle after srf_read_enable).
- srf_data2  in  MIN_VEC_LENGTH x NUM_TILES_PER_SLICE  SRF read data 2.
- srf_write_enable  out  1  SRF write strobe.
- stream_dest  out  NUM_STREAM_ID  SRF write address.
- write_data  out  MIN_VEC_LENGTH x NUM_TILES_PER_SLICE  result vector.
- done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  one-cycle pulse when an instruction is rejected.
- retired_count  out  CNT_W  count of legally retired instructions.

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - instr_ready=1; srf_read_enable=0; srf_write_enable=0; done=0; illegal_op=0; retired_count=0.
  - stream_src1/src2/dest=0; write_data all tiles 0.
  - Reset mid-instruction abandons it: no SRF write is issued and the count does not change.
- Handshake: an instruction is accepted when instr_valid && instr_ready. instr_ready=1 only in IDLE. op/src1/src2/dest are captured into internal registers on accept.
- FSM states: IDLE, READ, EXEC, WRITE, ERR.
  - IDLE -> READ on accept with legal op (0-7); IDLE -> ERR on accept with op 8-15.
  - READ (1 cycle): srf_read_enable=1, stream_src1/src2 = captured sources.
  - EXEC (1 cycle): srf_data1/2 are valid here. The result for every tile is computed and registered into write_data.
  - WRITE (1 cycle): srf_write_enable=1, stream_dest=captured dest, write_data held. done=1 this cycle and retired_count increments. Next state is IDLE.
  - ERR (1 cycle): illegal_op=1; no SRF strobes; count unchanged; next state IDLE.
- Latency: accept at cycle N gives read strobe at N+1, write strobe and done at N+3, and instr_ready again at N+4. Throughput is one instruction per 4 cycles.
- Opcodes, all per tile, unsigned, modulo 2^MIN_VEC_LENGTH: 0 ADD, 1 SUB (a-b wraps), 2 MUL (low MIN_VEC_LENGTH bits), 3 MAX, 4 MIN, 5 AND, 6 OR, 7 XOR.
- The same source stream may be used for src1 and src2.
- dest may equal a source. This is safe because the read completes before the write, so no forwarding is required.
- write_data holds its last value outside WRITE. The stream_* outputs hold their last values.
- retired_count wraps from all-ones to 0.
- srf_read_enable and srf_write_enable are never high in the same cycle.

Decomposition:
- Shared package vxm_pkg holds:
  - opcode enum (VXM_ADD..VXM_XOR, 4-bit);
  - FSM state enum;
  - localparam VXM_NUM_LEGAL_OPS=8;
  - function is_legal_op.
- Sub-module vxm_lane_alu (combinational, one element: op, a, b -> result) is instantiated NUM_TILES_PER_SLICE times by generate.

Test Plan:
- Bench SRF model preloads stream 0 tiles = 1..20 and stream 4 tiles = 0x0A..0x1D. Issue ADD src1=0 src2=4 dest=8 -> at N+3 srf_write_enable=1, stream_dest=8, tile0=0x000B, tile19=0x0031; done pulse; retired_count=1.
- SUB src1=0 src2=4 -> tile0=0xFFF7 (wrap). MUL with both tiles 0x0100 -> tile=0x0000 (low bits).
- Opcode 9 accepted -> illegal_op at N+1; no read or write strobe; retired_count unchanged; instr_ready=1 at N+2.
- instr_valid held high with 3 back-to-back instructions -> accepts at cycles N, N+4, N+8; instr_ready low for the 3 cycles between accepts; dest=src (XOR 0,0 -> dest 0) writes all zeros.
- Assert rst_n low during EXEC -> all outputs zero asynchronously; no srf_write_enable afterwards; retired_count=0.
- Preload retired_count to 0xFFFF via 65535 ops, then one more -> count wraps to 0x0000. Check never both SRF strobes high (assertion).

Source files
------------

// File: rtl/vxm_pkg.sv
// Shared types for the vector execute stage: opcodes, FSM states, legality check.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package vxm_pkg;

   typedef enum logic [3:0] {
      VXM_ADD = 4'd0,
      VXM_SUB = 4'd1,
      VXM_MUL = 4'd2,
      VXM_MAX = 4'd3,
      VXM_MIN = 4'd4,
      VXM_AND = 4'd5,
      VXM_OR  = 4'd6,
      VXM_XOR = 4'd7
   } vxm_op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_EXEC  = 3'd2,
      ST_WRITE = 3'd3,
      ST_ERR   = 3'd4
   } vxm_state_e;

   localparam int VXM_NUM_LEGAL_OPS = 8;

   // Opcodes 0..7 are defined; anything above is rejected by the stage.
   function automatic logic is_legal_op(input logic [3:0] op);
      return (32'(op) < VXM_NUM_LEGAL_OPS);
   endfunction

endpackage

// File: rtl/vxm_lane_alu.sv
// One tile lane: unsigned element-wise op on two W-bit operands, result modulo 2^W.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
module vxm_lane_alu
   import vxm_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [3:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] result
);

   // Select the lane result; undefined opcodes never reach here legally, so they yield zero.
   always_comb begin
      result = '0;
      case (op)
         VXM_ADD: result = a + b;
         VXM_SUB: result = a - b;
         VXM_MUL: result = a * b;
         VXM_MAX: result = (a > b) ? a : b;
         VXM_MIN: result = (a < b) ? a : b;
         VXM_AND: result = a & b;
         VXM_OR:  result = a | b;
         VXM_XOR: result = a ^ b;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/vxm_stream_exec.sv
// Vector execute stage: SRF read of two streams, per-tile ALU, SRF write of the result.
// Latency: accept at N -> read strobe N+1, write strobe/done N+3, ready again N+4 (illegal: pulse N+1, ready N+2).
// Backpressure: instr_ready is high only in IDLE, so one instruction is in flight at a time.
module vxm_stream_exec
   import vxm_pkg::*;
#(
   parameter int NUM_STREAM_ID       = 5,
   parameter int MIN_VEC_LENGTH      = 16,
   parameter int NUM_TILES_PER_SLICE = 20,
   parameter int CNT_W               = 16
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          instr_valid,
   output logic                                          instr_ready,
   input  logic [3:0]                                    instr_op,
   input  logic [NUM_STREAM_ID-1:0]                      instr_src1,
   input  logic [NUM_STREAM_ID-1:0]                      instr_src2,
   input  logic [NUM_STREAM_ID-1:0]                      instr_dest,
   output logic                                          srf_read_enable,
   output logic [NUM_STREAM_ID-1:0]                      stream_src1,
   output logic [NUM_STREAM_ID-1:0]                      stream_src2,
   input  logic [MIN_VEC_LENGTH*NUM_TILES_PER_SLICE-1:0] srf_data1,
   input  logic [MIN_VEC_LENGTH*NUM_TILES_PER_SLICE-1:0] srf_data2,
   output logic                                          srf_write_enable,
   output logic [NUM_STREAM_ID-1:0]                      stream_dest,
   output logic [MIN_VEC_LENGTH*NUM_TILES_PER_SLICE-1:0] write_data,
   output logic                                          done,
   output logic                                          illegal_op,
   output logic [CNT_W-1:0]                              retired_count
);

   localparam int VW = MIN_VEC_LENGTH * NUM_TILES_PER_SLICE;

   vxm_state_e               state;
   vxm_state_e               state_next;
   logic [3:0]               op_q;
   logic [NUM_STREAM_ID-1:0] dest_q;
   logic                     accept;
   logic [VW-1:0]            alu_result;

   assign accept = instr_valid && instr_ready;

   // State register; reset abandons any in-flight instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Next state and the per-state strobes; every strobe is a pure decode of the current state.
   always_comb begin
      state_next       = state;
      instr_ready      = 1'b0;
      srf_read_enable  = 1'b0;
      srf_write_enable = 1'b0;
      done             = 1'b0;
      illegal_op       = 1'b0;
      case (state)
         ST_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) state_next = is_legal_op(instr_op) ? ST_READ : ST_ERR;
         end
         ST_READ: begin
            srf_read_enable = 1'b1;
            state_next      = ST_EXEC;
         end
         ST_EXEC:  state_next = ST_WRITE;
         ST_WRITE: begin
            srf_write_enable = 1'b1;
            done             = 1'b1;
            state_next       = ST_IDLE;
         end
         ST_ERR: begin
            illegal_op = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Capture the instruction on accept; read addresses only move for legal ops so they hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q        <= '0;
         dest_q      <= '0;
         stream_src1 <= '0;
         stream_src2 <= '0;
      end else if (accept) begin
         op_q   <= instr_op;
         dest_q <= instr_dest;
         if (is_legal_op(instr_op)) begin
            stream_src1 <= instr_src1;
            stream_src2 <= instr_src2;
         end
      end
   end

   // One ALU per tile; SRF data is valid during EXEC.
   for (genvar t = 0; t < NUM_TILES_PER_SLICE; t++) begin : g_lane
      vxm_lane_alu #(.W(MIN_VEC_LENGTH)) u_lane (
         .op     (op_q),
         .a      (srf_data1[t*MIN_VEC_LENGTH +: MIN_VEC_LENGTH]),
         .b      (srf_data2[t*MIN_VEC_LENGTH +: MIN_VEC_LENGTH]),
         .result (alu_result[t*MIN_VEC_LENGTH +: MIN_VEC_LENGTH])
      );
   end

   // Register the result and write address at the end of EXEC; both hold until the next write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_data  <= '0;
         stream_dest <= '0;
      end else if (state == ST_EXEC) begin
         write_data  <= alu_result;
         stream_dest <= dest_q;
      end
   end

   // Retired count advances as WRITE completes and wraps naturally at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 retired_count <= '0;
      else if (state == ST_WRITE) retired_count <= retired_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_vxm_stream_exec.sv
// Scoreboard bench for vxm_stream_exec with an SRF behavioural model.
// A narrow-counter second instance shares all stimulus to exercise counter wrap quickly.
module tb_vxm_stream_exec;

   localparam int NS = 5;
   localparam int EW = 16;
   localparam int NT = 20;
   localparam int VW = EW * NT;

   logic          clk;
   logic          rst_n;
   logic          instr_valid;
   logic [3:0]    instr_op;
   logic [NS-1:0] instr_src1, instr_src2, instr_dest;
   logic [VW-1:0] srf_data1, srf_data2;

   logic          instr_ready, srf_read_enable, srf_write_enable, done, illegal_op;
   logic [NS-1:0] stream_src1, stream_src2, stream_dest;
   logic [VW-1:0] write_data;
   logic [15:0]   retired_count;

   logic          rdy2, rd2, wr2, done2, ill2;
   logic [NS-1:0] s1_2, s2_2, d_2;
   logic [VW-1:0] wd2;
   logic [3:0]    cnt2;

   vxm_stream_exec dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
      .instr_src1(instr_src1), .instr_src2(instr_src2), .instr_dest(instr_dest),
      .srf_read_enable(srf_read_enable), .stream_src1(stream_src1), .stream_src2(stream_src2),
      .srf_data1(srf_data1), .srf_data2(srf_data2),
      .srf_write_enable(srf_write_enable), .stream_dest(stream_dest), .write_data(write_data),
      .done(done), .illegal_op(illegal_op), .retired_count(retired_count)
   );

   vxm_stream_exec #(.CNT_W(4)) dut_w4 (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(rdy2), .instr_op(instr_op),
      .instr_src1(instr_src1), .instr_src2(instr_src2), .instr_dest(instr_dest),
      .srf_read_enable(rd2), .stream_src1(s1_2), .stream_src2(s2_2),
      .srf_data1(srf_data1), .srf_data2(srf_data2),
      .srf_write_enable(wr2), .stream_dest(d_2), .write_data(wd2),
      .done(done2), .illegal_op(ill2), .retired_count(cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   a_no_dual_strobe: assert property (@(posedge clk) !(srf_read_enable && srf_write_enable))
      else $error("FAIL dual_strobe: read and write enable both high");

   // ---------------- SRF model ----------------
   logic [EW-1:0] init_mem [32][NT];
   logic [EW-1:0] mem      [32][NT];
   logic          srf_loaded = 1'b0;

   initial begin
      for (int s = 0; s < 32; s++)
         for (int t = 0; t < NT; t++)
            init_mem[s][t] = 16'($urandom);
      for (int t = 0; t < NT; t++) begin
         init_mem[0][t] = 16'(t + 1);
         init_mem[4][t] = 16'(10 + t);
         init_mem[5][t] = 16'h0100;
      end
   end

   always @(posedge clk) begin
      if (!srf_loaded) begin
         mem        <= init_mem;
         srf_loaded <= 1'b1;
      end else begin
         if (srf_read_enable)
            for (int t = 0; t < NT; t++) begin
               srf_data1[t*EW +: EW] <= mem[stream_src1][t];
               srf_data2[t*EW +: EW] <= mem[stream_src2][t];
            end
         if (srf_write_enable)
            for (int t = 0; t < NT; t++)
               mem[stream_dest][t] <= write_data[t*EW +: EW];
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [EW-1:0] ref_op(input int op, input logic [EW-1:0] a, input logic [EW-1:0] b);
      longint x = a;
      longint y = b;
      longint r;
      case (op)
         0: r = x + y;
         1: r = x - y;
         2: r = x * y;
         3: r = (x > y) ? x : y;
         4: r = (x < y) ? x : y;
         5: r = x & y;
         6: r = x | y;
         7: r = x ^ y;
         default: r = 0;
      endcase
      return 16'(r);
   endfunction

   typedef struct {
      int            acc;
      bit            legal;
      logic [NS-1:0] s1;
      logic [NS-1:0] s2;
      logic [NS-1:0] dst;
      logic [VW-1:0] data;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          acc_e;
   logic [EW-1:0] ref_mem [32][NT];
   bit            ref_loaded = 1'b0;

   // Issue side: each accepted instruction pushes its expected outcome.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) exp_q.delete();
         else if (instr_valid && instr_ready && ref_loaded) begin
            acc_e.acc   = cyc;
            acc_e.legal = (instr_op < 4'd8);
            acc_e.s1    = instr_src1;
            acc_e.s2    = instr_src2;
            acc_e.dst   = instr_dest;
            acc_e.data  = '0;
            for (int t = 0; t < NT; t++)
               acc_e.data[t*EW +: EW] = ref_op(int'(instr_op), ref_mem[instr_src1][t], ref_mem[instr_src2][t]);
            exp_q.push_back(acc_e);
         end
      end
   end

   // ---------------- monitor ----------------
   int            n_cmp = 0;
   int            n_err = 0;
   logic [31:0]   mcnt = 0;
   logic [NS-1:0] last_s1 = 0, last_s2 = 0, last_dst = 0;
   logic [VW-1:0] last_wd = 0;
   bit            have, exp_rdy, exp_rd, exp_wr, exp_ill;

   task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, req);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!ref_loaded) begin
            ref_mem    = init_mem;
            ref_loaded = 1'b1;
         end
         if (!rst_n) begin
            chk("reset_strobes", {instr_ready, srf_read_enable, srf_write_enable, done, illegal_op}, 5'b10000);
            chk("reset_streams", {stream_src1, stream_src2, stream_dest}, '0);
            chk("reset_write_data", write_data, '0);
            chk("reset_count", retired_count, '0);
            mcnt = 0; last_s1 = 0; last_s2 = 0; last_dst = 0; last_wd = 0;
         end else begin
            have    = (exp_q.size() > 0);
            exp_rdy = !have || (exp_q[0].acc == cyc);
            exp_rd  = have &&  exp_q[0].legal && (cyc == exp_q[0].acc + 1);
            exp_wr  = have &&  exp_q[0].legal && (cyc == exp_q[0].acc + 3);
            exp_ill = have && !exp_q[0].legal && (cyc == exp_q[0].acc + 1);
            if (exp_rd) begin last_s1 = exp_q[0].s1; last_s2 = exp_q[0].s2; end
            if (exp_wr) begin last_dst = exp_q[0].dst; last_wd = exp_q[0].data; end
            chk("instr_ready", instr_ready, exp_rdy);
            chk("strobes rd/wr/done/ill", {srf_read_enable, srf_write_enable, done, illegal_op},
                {exp_rd, exp_wr, exp_wr, exp_ill});
            chk("stream_src", {stream_src1, stream_src2}, {last_s1, last_s2});
            chk("stream_dest", stream_dest, last_dst);
            chk("write_data", write_data, last_wd);
            chk("retired_count", retired_count, mcnt[15:0]);
            chk("retired_count_w4", cnt2, mcnt[3:0]);
            chk("narrow_instance_mirror", {rdy2, rd2, wr2, done2, ill2, s1_2, s2_2, d_2, wd2},
                {instr_ready, srf_read_enable, srf_write_enable, done, illegal_op,
                 stream_src1, stream_src2, stream_dest, write_data});
            if (exp_wr) begin
               for (int t = 0; t < NT; t++) ref_mem[exp_q[0].dst][t] = exp_q[0].data[t*EW +: EW];
               mcnt = mcnt + 1;
               void'(exp_q.pop_front());
            end else if (exp_ill) begin
               void'(exp_q.pop_front());
            end else if (have && (cyc > exp_q[0].acc + 5)) begin
               n_cmp++;
               n_err++;
               $display("FAIL completion_timeout @cyc %0d: instr accepted at %0d never retired", cyc, exp_q[0].acc);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [3:0] op, input logic [NS-1:0] s1, input logic [NS-1:0] s2,
                        input logic [NS-1:0] d, input bit keep);
      int waited;
      instr_op    = op;
      instr_src1  = s1;
      instr_src2  = s2;
      instr_dest  = d;
      instr_valid = 1'b1;
      waited      = 0;
      forever begin
         @(negedge clk);
         if (instr_ready) break;
         waited++;
         if (waited > 20) begin
            $display("FAIL accept_timeout @cyc %0d: instr_ready never rose", cyc);
            $fatal(1);
         end
      end
      @(posedge clk);
      #1;
      if (!keep) instr_valid = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int gap;
      bit keep;
      logic [3:0] op;
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr_op    = '0;
      instr_src1  = '0;
      instr_src2  = '0;
      instr_dest  = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue(4'd0, 5'd0, 5'd4, 5'd8,  1'b0);   // ADD: tile0 0x000B, tile19 0x0031
      issue(4'd1, 5'd0, 5'd4, 5'd9,  1'b0);   // SUB wraps: tile0 0xFFF7
      issue(4'd2, 5'd5, 5'd5, 5'd10, 1'b0);   // MUL 0x0100*0x0100 -> 0x0000
      issue(4'd9, 5'd1, 5'd2, 5'd3,  1'b0);   // illegal opcode
      repeat (2) begin @(posedge clk); #1; end

      issue(4'd0, 5'd0, 5'd4, 5'd11, 1'b1);   // three back-to-back with valid held
      issue(4'd7, 5'd0, 5'd0, 5'd0,  1'b1);   // XOR 0,0 -> dest 0 all zeros
      issue(4'd3, 5'd4, 5'd0, 5'd12, 1'b0);

      issue(4'd0, 5'd4, 5'd4, 5'd13, 1'b0);   // reset during EXEC of this one
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) begin @(posedge clk); #1; end

      for (int i = 0; i < 400; i++) begin
         op   = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
         keep = ($urandom_range(0, 3) == 0);
         issue(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), keep);
         gap = keep ? 0 : $urandom_range(0, 3);
         repeat (gap) begin @(posedge clk); #1; end
      end
      instr_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
